// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants for the fetch stage and downstream pipeline registers.
package fetch_stage_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0
    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register: flush beats load, otherwise hold. Valid travels with the data.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_p0,
    input  logic [ADDR_W-1:0]  pc4_p0,
    output logic [INSTR_W-1:0] instr_p1,
    output logic [ADDR_W-1:0]  pc4_p1,
    output logic               vld_p1
);

    // p0 -> p1 stage boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p1 <= NOP_INSTR;
            pc4_p1   <= '0;
            vld_p1   <= 1'b0;
        end else if (flush) begin
            instr_p1 <= NOP_INSTR;
            pc4_p1   <= '0;
            vld_p1   <= 1'b0;
        end else if (load) begin
            instr_p1 <= instr_p0;
            pc4_p1   <= pc4_p0;
            vld_p1   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem address, IF/ID register, stall and redirect handling.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc4,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count,
    output logic [31:0]        flush_count,
`endif
    output logic               ifid_valid
);

    logic [ADDR_W-1:0] pc_plus4;
    logic              advance;

    // Carry out of the adder is dropped so the PC wraps silently.
    assign pc_plus4  = pc + ADDR_W'(PC_STEP);
    assign advance   = !stall && !redirect;
    assign imem_addr = pc;

    // PC register stage boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= {redirect_target[ADDR_W-1:2], 2'b00};
        end else if (advance) begin
            pc <= pc_plus4;
        end
    end

    ifid_reg #(
        .ADDR_W(ADDR_W)
    ) u_ifid (
        .clk     (clk),
        .rst_n   (reset),
        .load    (advance),
        .flush   (redirect),
        .instr_p0(imem_data),
        .pc4_p0  (pc_plus4),
        .instr_p1(ifid_instr),
        .pc4_p1  (ifid_pc4),
        .vld_p1  (ifid_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    // Counter stage boundary: one counter per edge category, same priority as the PC update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (redirect) begin
            flush_count <= flush_count + 32'd1;
        end else if (stall) begin
            stall_count <= stall_count + 32'd1;
        end else begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a reference-model scoreboard; second instance exercises PC wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] imem_addr, imem_data, pc, ifid_instr, ifid_pc4;
    logic        ifid_valid;
    logic [31:0] imem_addr_w, imem_data_w, pc_w, ifid_instr_w, ifid_pc4_w;
    logic        ifid_valid_w;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count, flush_count;
    logic [31:0] fetch_count_w, stall_count_w, flush_count_w;
`endif

    logic [31:0] mem [0:63];
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;

    always #5 clk = ~clk;

    assign imem_data   = mem[imem_addr[7:2]];
    assign imem_data_w = imem_addr_w ^ 32'h5A5A_0000;

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .pc(pc), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fetch_count), .stall_count(stall_count), .flush_count(flush_count),
`endif
        .ifid_valid(ifid_valid)
    );

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0),
        .redirect_target(32'h0), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
        .pc(pc_w), .ifid_instr(ifid_instr_w), .ifid_pc4(ifid_pc4_w),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fetch_count_w), .stall_count(stall_count_w), .flush_count(flush_count_w),
`endif
        .ifid_valid(ifid_valid_w)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus, predict the post-edge state, then compare after the edge.
    task automatic step(input string tag, input logic s, input logic r, input logic [31:0] tgt);
        exp_t e;
        stall = s; redirect = r; redirect_target = tgt;
        if (r) begin
            m_pc = {tgt[31:2], 2'b00}; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = mem[m_pc[7:2]]; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
        sb.push_back('{m_pc, m_instr, m_pc4, m_valid});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".pc"},    64'(pc),         64'(e.pc));
        chk({tag, ".instr"}, 64'(ifid_instr), 64'(e.instr));
        chk({tag, ".pc4"},   64'(ifid_pc4),   64'(e.pc4));
        chk({tag, ".valid"}, 64'(ifid_valid), 64'(e.valid));
        chk({tag, ".addr"},  64'(imem_addr),  64'(pc));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0003;
        model_reset();

        // Reset held low
        #12;
        chk("rst.pc",     64'(pc),         64'h0);
        chk("rst.instr",  64'(ifid_instr), 64'h0);
        chk("rst.pc4",    64'(ifid_pc4),   64'h0);
        chk("rst.valid",  64'(ifid_valid), 64'h0);
        chk("rst.pc_w",   64'(pc_w),       64'hFFFF_FFFC);
        reset = 1'b1;

        // Free run from RESET_PC; wrap instance checked alongside
        step("run0", 1'b0, 1'b0, 32'h0);
        chk("run0.instr_k", 64'(ifid_instr), 64'h2008_0001);
        chk("wrap0.pc",     64'(pc_w),       64'h0);
        chk("wrap0.pc4",    64'(ifid_pc4_w), 64'h0);
        chk("wrap0.instr",  64'(ifid_instr_w), 64'hA5A5_FFFC);
        chk("wrap0.valid",  64'(ifid_valid_w), 64'h1);
        step("run1", 1'b0, 1'b0, 32'h0);
        chk("run1.instr_k", 64'(ifid_instr), 64'h2009_0003);
        chk("run1.pc4_k",   64'(ifid_pc4),   64'h8);
        chk("wrap1.pc",     64'(pc_w),       64'h4);
        chk("wrap1.pc4",    64'(ifid_pc4_w), 64'h4);

        // Stall holds everything
        for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 32'h0);
        chk("stall.pc_k", 64'(pc), 64'h8);
        step("unstall", 1'b0, 1'b0, 32'h0);
        chk("unstall.pc_k", 64'(pc), 64'hC);
        step("run2", 1'b0, 1'b0, 32'h0);
        chk("run2.pc_k", 64'(pc), 64'h10);

        // Redirect: one bubble, target word next
        step("redir", 1'b0, 1'b1, 32'h40);
        chk("redir.pc_k", 64'(pc), 64'h40);
        step("redir_tgt", 1'b0, 1'b0, 32'h0);
        chk("redir_tgt.instr_k", 64'(ifid_instr), 64'(32'hA000_0010));
        chk("redir_tgt.pc4_k",   64'(ifid_pc4),   64'h44);

        // Stall and redirect together, misaligned target
        step("stall_redir", 1'b1, 1'b1, 32'h23);
        chk("stall_redir.pc_k", 64'(pc), 64'h20);

        // Redirect held for consecutive cycles
        step("hold_redir0", 1'b0, 1'b1, 32'h30);
        step("hold_redir1", 1'b1, 1'b1, 32'h35);
        for (int i = 0; i < 3; i++) step("run3", 1'b0, 1'b0, 32'h0);

        // Reset pulsed between edges in the middle of a stall
        step("pre_rst_stall", 1'b1, 1'b0, 32'h0);
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst.pc",    64'(pc),         64'h0);
        chk("async_rst.valid", 64'(ifid_valid), 64'h0);
        chk("async_rst.instr", 64'(ifid_instr), 64'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("async_rst.fcnt", 64'(fetch_count), 64'h0);
        chk("async_rst.scnt", 64'(stall_count), 64'h0);
        chk("async_rst.xcnt", 64'(flush_count), 64'h0);
`endif
        redirect = 1'b1; redirect_target = 32'h80; stall = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ignores.pc",    64'(pc),         64'h0);
        chk("rst_ignores.valid", 64'(ifid_valid), 64'h0);
        redirect = 1'b0;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) step("post_rst", 1'b0, 1'b0, 32'h0);
        chk("post_rst.pc_k", 64'(pc), 64'h14);
`ifdef FETCH_PERF_CNT_EN
        chk("post_rst.fcnt", 64'(fetch_count), 64'h5);
        chk("post_rst.scnt", 64'(stall_count), 64'h0);
        chk("post_rst.xcnt", 64'(flush_count), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the pipelined MIPS CPU. It sits directly upstream of decode and feeds the IF/ID pipeline register.
- Owns the program counter, drives the instruction-memory read address and captures the returned word.
- Applies load-use stalls from the hazard unit and branch/jump redirects resolved downstream.
- Emits instruction, PC+4 and a valid bit to decode.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word aligned.
- ADDR_W, 32: PC and address width in bits.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; one clock; polarity and synchronicity fixed.
- stall  input  1  hazard unit: hold PC and IF/ID.
- redirect  input  1  taken branch or jump resolved downstream.
- redirect_target  input  ADDR_W  new fetch address.
- imem_addr  output  ADDR_W  byte address to instruction memory; memory indexes word addr>>2.
- imem_data  input  32  instruction word; combinational, same cycle as imem_addr.
- pc  output  ADDR_W  current fetch PC.
- ifid_instr  output  32  instruction to decode.
- ifid_pc4  output  ADDR_W  PC+4 of that instruction, for branch/jal link.
- ifid_valid  output  1  ifid_instr is a real instruction.

Behaviour:
- Reset values (asserted low, takes effect immediately, asynchronous):
  - pc = RESET_PC
  - ifid_instr = 32'h0000_0000 (sll $0,$0,0 NOP)
  - ifid_pc4 = 0
  - ifid_valid = 0
- imem_addr = pc, combinational, always driven.
- Per rising edge, in priority order:
  1. redirect=1: pc <= {redirect_target[ADDR_W-1:2],2'b00}; ifid_instr <= NOP; ifid_pc4 <= 0; ifid_valid <= 0. The wrong-path instruction is flushed.
  2. stall=1 (and no redirect): pc, ifid_instr, ifid_pc4 and ifid_valid all hold.
  3. Otherwise: ifid_instr <= imem_data; ifid_pc4 <= pc+4; ifid_valid <= 1; pc <= pc+4.
- Latency: the instruction at address A appears on ifid_instr one edge after pc==A with no stall.
- Redirect penalty: exactly one bubble in IF/ID. The target instruction reaches IF/ID two edges after redirect is sampled.
- Simultaneous stall and redirect: redirect wins. The stalled instruction is wrong-path and is discarded.
- Redirect held high for consecutive cycles: each cycle reloads pc from the current target. ifid_valid stays 0 throughout.
- Misaligned target: low two bits are forced to 0. No trap is raised.
- Wrap-around: pc = 32'hFFFF_FFFC increments to 0 with no flag. ifid_pc4 wraps identically.
- First edge after reset release: captures the word at RESET_PC. ifid_valid rises after that edge.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values at once. Inputs are ignored while reset is low.
- The PC adder is ADDR_W bits, unsigned, and the carry is discarded.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, three extra outputs are added, each 32-bit, reset to 0 and wrapping on overflow:
  - fetch_count: counts case-3 edges.
  - stall_count: counts case-2 edges.
  - flush_count: counts case-1 edges.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared cpu package holds:
  - INSTR_W=32
  - NOP_INSTR=32'h0
  - PC_STEP=4
  - the default RESET_PC constant; decode uses the same NOP.
- One sub-module, ifid_reg: the IF/ID register, with inputs load, flush, instr, pc4 and outputs instr, pc4, valid.
  - Flush has priority over load.
  - Hold when neither is asserted.
  - Reused for the ID/EX valid-bit style.

Test Plan:
- Reset release, memory words 0x20080001 @0, 0x20090003 @4 → pc steps 0,4,8. ifid_instr is 0x20080001 then 0x20090003; ifid_pc4 is 4 then 8; ifid_valid=1 from the first edge.
- stall=1 for 3 edges while pc=8 → pc stays 8, ifid_instr stays 0x20090003. After release, the next edge captures word @8 and pc=12.
- redirect=1 with redirect_target=0x40 while pc=0x10 → next edge pc=0x40, ifid_valid=0, ifid_instr=0. The following edge gives ifid_instr=mem[0x10] (word index) and ifid_pc4=0x44.
- stall=1 and redirect=1 together, target 0x23 → pc=0x20 (aligned), ifid_valid=0.
- RESET_PC=32'hFFFF_FFFC, free run → pc goes 0xFFFFFFFC then 0. ifid_pc4=0 for the word fetched at 0xFFFFFFFC.
- Reset pulsed low mid-stall (between edges), with FETCH_PERF_CNT_EN defined → pc=RESET_PC, ifid_valid=0 and all counters 0 immediately, without waiting for a clock edge. After 5 plain fetches, fetch_count=5.
